vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor to the team's fixed 640x480 VGA controller.
- Generates raw pixel/line counters, a scaled framebuffer read address, and sync/valid signals.
- Sync/valid are delayed by a configurable pipeline depth so they line up with a framebuffer RAM of any read latency.
- Adds a count-enable input, selectable sync polarity, and frame/line start strobes. Sits between the pixel clock domain and the block-RAM framebuffer / pixel mux.

Parameters:
HD, 640, horizontal active pixels
HF, 16, horizontal front porch
HS, 96, horizontal sync width
HB, 48, horizontal back porch
VD, 480, vertical active lines
VF, 10, vertical front porch
VS, 2, vertical sync width
VB, 33, vertical back porch
HSYNC_ACT, 0, hsync asserted level (0 = active-low)
VSYNC_ACT, 0, vsync asserted level
CNT_W, 10, counter width; must hold HT-1 and VT-1
SCALE_SHIFT, 0, log2 of pixel replication factor for address generation
FB_W, HD>>SCALE_SHIFT, framebuffer row pitch in cells
ADDR_W, 19, framebuffer address width
PIPE_DLY, 1, framebuffer read latency in cycles (0..4)

Ports:
pclk  input  1  pixel clock
rst_n  input  1  synchronous active-low reset
en  input  1  count enable; low freezes counters and delay pipeline
h_cnt  output  CNT_W  raw horizontal counter (stage 0)
v_cnt  output  CNT_W  raw vertical counter (stage 0)
fb_addr  output  ADDR_W  framebuffer read address (stage 0)
line_start  output  1  high while h_cnt==0 (stage 0)
frame_start  output  1  high while h_cnt==0 and v_cnt==0 (stage 0)
hsync  output  1  horizontal sync, delayed PIPE_DLY
vsync  output  1  vertical sync, delayed PIPE_DLY
valid  output  1  active-video flag, delayed PIPE_DLY

Behaviour:
- HT = HD+HF+HS+HB, VT = VD+VF+VS+VB.
- Reset is sampled only on the pclk edge:
  - h_cnt = v_cnt = 0.
  - All delay stages cleared to hsync = ~HSYNC_ACT, vsync = ~VSYNC_ACT, valid = 0.
  - Reset overrides en.
- Counters, on each edge with en=1:
  - h_cnt increments and wraps HT-1 -> 0.
  - When h_cnt==HT-1, v_cnt increments and wraps VT-1 -> 0.
  - The simultaneous wrap at (HT-1,VT-1) goes to (0,0).
- en=0: all registers hold, including the delay pipeline. Outputs are static.
- Stage-0 decode, combinational from the counters:
  - act = (h_cnt<HD) && (v_cnt<VD).
  - hs0 = HSYNC_ACT when HD+HF <= h_cnt < HD+HF+HS, else ~HSYNC_ACT.
  - vs0 = VSYNC_ACT when VD+VF <= v_cnt < VD+VF+VS, else ~VSYNC_ACT. This is a whole-line granularity decode.
- fb_addr = (h_cnt>>SCALE_SHIFT) + FB_W*(v_cnt>>SCALE_SHIFT) when act, else 0.
  - Computed at full precision, then truncated to ADDR_W bits.
  - Combinational from the counters: stage 0, presented in the same cycle as h_cnt/v_cnt.
- hsync, vsync and valid are {hs0, vs0, act} passed through exactly PIPE_DLY registers.
  - PIPE_DLY=0: they are the stage-0 values combinationally.
  - Data read at fb_addr in cycle t is therefore qualified by valid in cycle t+PIPE_DLY.
- line_start and frame_start: stage 0, not delayed. Each lasts one cycle per line/frame while en=1, and holds while en=0.
- Line period is HT enabled cycles; frame period is HT*VT enabled cycles.
- Reset mid-frame:
  - Next cycle shows counters at 0 and frame_start=1.
  - Delayed outputs show inactive values for PIPE_DLY cycles, then track stage 0.
- Elaboration error if 2^CNT_W < HT or 2^CNT_W < VT, or if PIPE_DLY > 4.

Test Plan:
- Reset, defaults (PIPE_DLY=1): hold rst_n=0 for 3 cycles, release with en=1 → cycle 0 shows h_cnt=0, v_cnt=0, frame_start=1, valid=0; cycle 1 shows valid=1, h_cnt=1, hsync=1, vsync=1.
- Horizontal timing, defaults: run one line → hsync=0 for exactly 96 cycles, first low at h_cnt=657 (656+1 delay); line_start repeats every 800 cycles; valid is high for 640 cycles per active line.
- Frame timing, defaults: run 2 frames → frame_start period 420000 cycles; vsync low for 1600 cycles starting on line 490 (+1 cycle delay); valid=0 on lines 480..524.
- Address scaling, SCALE_SHIFT=5, FB_W=20 → at h_cnt=37, v_cnt=70, fb_addr=1+20*2=41; at h_cnt=640, fb_addr=0; at h_cnt=639, v_cnt=479, fb_addr=299.
- Enable stall, PIPE_DLY=3: drop en for 10 cycles at h_cnt=100 → h_cnt, hsync, vsync and valid frozen; on resume h_cnt=101; delayed outputs continue their sequence with no gap or duplicate.
- Polarity and reset mid-frame, HSYNC_ACT=1, VSYNC_ACT=1: hsync high only during h 656..751; assert rst_n=0 at v_cnt=200 → next cycle counters are 0, hsync=0, valid=0 for 1 delay cycle, then normal operation.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raw counters, scaled framebuffer address,
// and sync/valid delayed to line up with a framebuffer of PIPE_DLY read latency.
module vga_timing_gen #(
    parameter int HD          = 640,
    parameter int HF          = 16,
    parameter int HS          = 96,
    parameter int HB          = 48,
    parameter int VD          = 480,
    parameter int VF          = 10,
    parameter int VS          = 2,
    parameter int VB          = 33,
    parameter int HSYNC_ACT   = 0,
    parameter int VSYNC_ACT   = 0,
    parameter int CNT_W       = 10,
    parameter int SCALE_SHIFT = 0,
    parameter int FB_W        = HD >> SCALE_SHIFT,
    parameter int ADDR_W      = 19,
    parameter int PIPE_DLY    = 1
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              en,
    output logic [CNT_W-1:0]  h_cnt,
    output logic [CNT_W-1:0]  v_cnt,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              line_start,
    output logic              frame_start,
    output logic              hsync,
    output logic              vsync,
    output logic              valid
);

    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    if ((2 ** CNT_W) < HT || (2 ** CNT_W) < VT) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W too narrow for HT/VT");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_dly_check
        $error("vga_timing_gen: PIPE_DLY must be 0..4");
    end

    // Decode limits carry one extra bit so a sync window ending exactly at 2^CNT_W still compares correctly.
    localparam logic [CNT_W-1:0] HT_LAST  = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] VT_LAST  = CNT_W'(VT - 1);
    localparam logic [CNT_W:0]   H_ACT    = (CNT_W+1)'(HD);
    localparam logic [CNT_W:0]   V_ACT    = (CNT_W+1)'(VD);
    localparam logic [CNT_W:0]   H_S_BEG  = (CNT_W+1)'(HD + HF);
    localparam logic [CNT_W:0]   H_S_END  = (CNT_W+1)'(HD + HF + HS);
    localparam logic [CNT_W:0]   V_S_BEG  = (CNT_W+1)'(VD + VF);
    localparam logic [CNT_W:0]   V_S_END  = (CNT_W+1)'(VD + VF + VS);
    localparam logic             HS_ON    = 1'(HSYNC_ACT);
    localparam logic             VS_ON    = 1'(VSYNC_ACT);
    localparam logic [2:0]       IDLE     = {~HS_ON, ~VS_ON, 1'b0};

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_cnt_q == HT_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VT_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic [CNT_W:0] h_ext, v_ext;
    logic           act, hs0, vs0;
    logic [2:0]     stage0;

    assign h_ext  = {1'b0, h_cnt_q};
    assign v_ext  = {1'b0, v_cnt_q};
    assign act    = (h_ext < H_ACT) && (v_ext < V_ACT);
    assign hs0    = (h_ext >= H_S_BEG && h_ext < H_S_END) ? HS_ON : ~HS_ON;
    assign vs0    = (v_ext >= V_S_BEG && v_ext < V_S_END) ? VS_ON : ~VS_ON;
    assign stage0 = {hs0, vs0, act};

    // Modular arithmetic: truncating each term first gives the same low ADDR_W bits.
    logic [ADDR_W-1:0] addr_calc;
    assign addr_calc = ADDR_W'(h_cnt_q >> SCALE_SHIFT)
                     + ADDR_W'(FB_W) * ADDR_W'(v_cnt_q >> SCALE_SHIFT);

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign fb_addr     = act ? addr_calc : '0;
    assign line_start  = (h_cnt_q == '0);
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

    if (PIPE_DLY == 0) begin : g_nodly
        assign {hsync, vsync, valid} = stage0;
    end else begin : g_dly
        logic [2:0] pipe_q [PIPE_DLY];

        always_ff @(posedge pclk) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= IDLE;
                end
            end else if (en) begin
                pipe_q[0] <= stage0;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign {hsync, vsync, valid} = pipe_q[PIPE_DLY-1];
    end

endmodule
